// File: rtl/note_scheduler_pkg.sv
// Shared definitions for note_scheduler: note word field layout, sys codes,
// FSM state encoding and the unpacked note record.
package note_scheduler_pkg;

    localparam int SYS_MSB   = 31;
    localparam int SYS_LSB   = 29;
    localparam int PITCH_MSB = 28;
    localparam int PITCH_LSB = 23;
    localparam int STR_MSB   = 22;
    localparam int STR_LSB   = 20;
    localparam int FRET_MSB  = 19;
    localparam int FRET_LSB  = 16;
    localparam int TIME_MSB  = 15;
    localparam int TIME_LSB  = 0;

    localparam logic [2:0] SYS_NOTE = 3'b000;
    localparam logic [2:0] SYS_END  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_EVAL,
        ST_PRESENT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [5:0]  pitch;
        logic [2:0]  str;
        logic [3:0]  fret;
        logic [15:0] tm;
    } note_t;

    function automatic logic [2:0] word_sys(input logic [31:0] w);
        return w[SYS_MSB:SYS_LSB];
    endfunction

    function automatic note_t unpack_note(input logic [31:0] w);
        note_t n;
        n.pitch = w[PITCH_MSB:PITCH_LSB];
        n.str   = w[STR_MSB:STR_LSB];
        n.fret  = w[FRET_MSB:FRET_LSB];
        n.tm    = w[TIME_MSB:TIME_LSB];
        return n;
    endfunction

endpackage

// File: rtl/note_scheduler.sv
// Loads note words into the external BRAM and plays them out in address order,
// releasing each note once song time is within LOOKAHEAD ms of it.
// Optional: define NOTE_SCHED_MISS_EN to skip notes later than MISS_WINDOW ms.
module note_scheduler
    import note_scheduler_pkg::*;
#(
    parameter int          LOGSIZE     = 12,
    parameter logic [15:0] LOOKAHEAD   = 16'd2000,
    parameter logic [15:0] MISS_WINDOW = 16'd100
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               write_en,
    input  logic [31:0]        write_word,
    input  logic               start,
    input  logic [15:0]        song_time,
    output logic [LOGSIZE-1:0] mem_addr,
    output logic               mem_we,
    output logic [31:0]        mem_din,
    input  logic [31:0]        mem_dout,
    output logic               note_valid,
    input  logic               note_ready,
    output logic [5:0]         note_pitch,
    output logic [2:0]         note_string,
    output logic [3:0]         note_fret,
    output logic [15:0]        note_time,
`ifdef NOTE_SCHED_MISS_EN
    output logic [LOGSIZE:0]   missed_count,
`endif
    output logic               loaded,
    output logic               busy,
    output logic               done,
    output logic               wr_err
);

    localparam logic [LOGSIZE-1:0] ADDR_MAX = '1;

    state_t             state;
    logic [LOGSIZE-1:0] wr_ptr;
    logic [LOGSIZE-1:0] rd_ptr;
    logic               wr_full;
    logic [31:0]        note_w;
    note_t              note;
    logic               wr_drop;
    logic               due;

    assign note        = unpack_note(note_w);
    assign note_pitch  = note.pitch;
    assign note_string = note.str;
    assign note_fret   = note.fret;
    assign note_time   = note.tm;

    // Once the song is terminated or the memory is full, further writes are dropped.
    assign wr_drop  = loaded || wr_full;
    assign mem_we   = write_en && (state == ST_IDLE) && !wr_drop;
    assign mem_din  = mem_we ? write_word : 32'd0;
    assign mem_addr = (state == ST_IDLE) ? wr_ptr : rd_ptr;

    // 17-bit compare so song_time + LOOKAHEAD cannot wrap.
    assign due = ({1'b0, note.tm} <= ({1'b0, song_time} + {1'b0, LOOKAHEAD}));

`ifdef NOTE_SCHED_MISS_EN
    logic late;
    assign late = ({1'b0, song_time} > ({1'b0, note.tm} + {1'b0, MISS_WINDOW}));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_full    <= 1'b0;
            note_w     <= '0;
            note_valid <= 1'b0;
            loaded     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
`ifdef NOTE_SCHED_MISS_EN
            missed_count <= '0;
`endif
        end else begin
            if (write_en && ((state != ST_IDLE) || wr_drop))
                wr_err <= 1'b1;

            if (mem_we) begin
                if (word_sys(write_word) == SYS_END)
                    loaded <= 1'b1;
                if (wr_ptr == ADDR_MAX)
                    wr_full <= 1'b1;
                else
                    wr_ptr <= wr_ptr + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        wr_ptr  <= '0;
                        wr_full <= 1'b0;
                        loaded  <= 1'b0;
                    end else if (start && loaded) begin
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RD_ISSUE;
`ifdef NOTE_SCHED_MISS_EN
                        missed_count <= '0;
`endif
                    end
                end

                ST_RD_ISSUE: state <= ST_RD_WAIT;

                ST_RD_WAIT: begin
                    note_w <= mem_dout;
                    state  <= ST_EVAL;
                end

                ST_EVAL: begin
                    // Any non-note sys code terminates the song.
                    if (word_sys(note_w) != SYS_NOTE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
`ifdef NOTE_SCHED_MISS_EN
                    else if (late) begin
                        missed_count <= missed_count + 1'b1;
                        if (rd_ptr == ADDR_MAX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= ST_RD_ISSUE;
                        end
                    end
`endif
                    else if (due) begin
                        note_valid <= 1'b1;
                        state      <= ST_PRESENT;
                    end
                end

                ST_PRESENT: begin
                    if (note_ready) begin
                        note_valid <= 1'b0;
                        if (rd_ptr == ADDR_MAX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= ST_RD_ISSUE;
                        end
                    end
                end

                ST_DONE: begin
                    if (clear) begin
                        done    <= 1'b0;
                        wr_ptr  <= '0;
                        wr_full <= 1'b0;
                        loaded  <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (start) begin
                        done   <= 1'b0;
                        busy   <= 1'b1;
                        rd_ptr <= '0;
                        state  <= ST_RD_ISSUE;
`ifdef NOTE_SCHED_MISS_EN
                        missed_count <= '0;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a behavioural 1-cycle-latency BRAM.
// Covers load, playback, lookahead timing, back-pressure, overflow, and the optional miss skip.
module tb_note_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        write_en = 1'b0;
    logic [31:0] write_word = 32'd0;
    logic        start = 1'b0;
    logic [15:0] song_time = 16'd0;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic        note_valid;
    logic        note_ready = 1'b0;
    logic [5:0]  note_pitch;
    logic [2:0]  note_string;
    logic [3:0]  note_fret;
    logic [15:0] note_time;
    logic        loaded, busy, done, wr_err;
`ifdef NOTE_SCHED_MISS_EN
    logic [12:0] missed_count;
`endif

    localparam logic [31:0] END_W = 32'hE000_0000;

    int n_assert = 0;
    int n_fail   = 0;

    note_scheduler dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .write_en(write_en), .write_word(write_word), .start(start),
        .song_time(song_time), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout), .note_valid(note_valid),
        .note_ready(note_ready), .note_pitch(note_pitch), .note_string(note_string),
        .note_fret(note_fret), .note_time(note_time),
`ifdef NOTE_SCHED_MISS_EN
        .missed_count(missed_count),
`endif
        .loaded(loaded), .busy(busy), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] w);
        write_en = 1'b1;
        write_word = w;
        step();
        write_en = 1'b0;
        write_word = 32'd0;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] p, input logic [2:0] s,
                                       input logic [3:0] f, input logic [15:0] t);
        return {3'b000, p, s, f, t};
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!note_valid && cyc < 50) begin
            step();
            cyc++;
        end
        if (!note_valid) chk("valid_timeout", {31'd0, note_valid}, 32'd1);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done && cyc < 50) begin
            step();
            cyc++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int k;
        logic [15:0] seen [3];
        logic ok;

        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

        // reset state
        step(); step();
        chk("rst_valid", {31'd0, note_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_loaded", {31'd0, loaded}, 32'd0);
        chk("rst_wr_err", {31'd0, wr_err}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        reset_n = 1'b1;
        step();

        // load three notes and END, play with everything due
        wr(mk(6'd1, 3'd1, 4'd1, 16'd100));
        wr(mk(6'd2, 3'd2, 4'd2, 16'd200));
        wr(mk(6'd3, 3'd3, 4'd3, 16'd300));
        chk("loaded_before_end", {31'd0, loaded}, 32'd0);
        write_en = 1'b1;
        write_word = END_W;
        #1;
        chk("mem_we_comb", {31'd0, mem_we}, 32'd1);
        chk("end_addr", {20'd0, mem_addr}, 32'd3);
        step();
        write_en = 1'b0;
        write_word = 32'd0;
        chk("loaded_after_end", {31'd0, loaded}, 32'd1);

        song_time = 16'd0;
        note_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_valid(c);
            chk("note_latency", c, 32'd3);
            chk("pitch", {26'd0, note_pitch}, i + 1);
            chk("string", {29'd0, note_string}, i + 1);
            chk("fret", {28'd0, note_fret}, i + 1);
            chk("time", {16'd0, note_time}, (i + 1) * 100);
            step();
        end
        wait_done();
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_valid", {31'd0, note_valid}, 32'd0);

        // write outside IDLE is dropped and flagged
        wr(mk(6'd9, 3'd0, 4'd0, 16'd9));
        chk("wr_err_done", {31'd0, wr_err}, 32'd1);
        chk("still_done", {31'd0, done}, 32'd1);

        // lookahead timing: times 2100/2200/2300 fall due at song_time 100/200/300
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_done", {31'd0, done}, 32'd0);
        chk("clear_loaded", {31'd0, loaded}, 32'd0);
        wr(mk(6'd11, 3'd1, 4'd5, 16'd2100));
        wr(mk(6'd12, 3'd2, 4'd6, 16'd2200));
        wr(mk(6'd13, 3'd3, 4'd7, 16'd2300));
        wr(END_W);
        song_time = 16'd95;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (note_valid && k < 3) begin
                seen[k] = song_time;
                k++;
            end
            song_time = song_time + 16'd1;
        end
        chk("step_count", k, 32'd3);
        chk("step_t0", {16'd0, seen[0]}, 32'd100);
        chk("step_t1", {16'd0, seen[1]}, 32'd200);
        chk("step_t2", {16'd0, seen[2]}, 32'd300);
        chk("step_done", {31'd0, done}, 32'd1);

        // replay from DONE with back-pressure; clear while busy is ignored
        song_time = 16'd300;
        note_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(c);
        chk("replay_pitch", {26'd0, note_pitch}, 32'd11);
        chk("replay_addr", {20'd0, mem_addr}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) clear = 1'b1;
            step();
            clear = 1'b0;
            ok = note_valid && busy && note_pitch == 6'd11 && note_time == 16'd2100 &&
                 note_fret == 4'd5 && mem_addr == 12'd0;
            chk("hold", {31'd0, ok}, 32'd1);
        end

        // asynchronous reset mid-PRESENT
        reset_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, note_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_pitch", {26'd0, note_pitch}, 32'd0);
        chk("ar_time", {16'd0, note_time}, 32'd0);
        chk("ar_wr_err", {31'd0, wr_err}, 32'd0);
        chk("ar_loaded", {31'd0, loaded}, 32'd0);
        chk("ar_addr", {20'd0, mem_addr}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // overflow: 4096 notes fill memory, the 4097th is dropped
        for (int i = 0; i < 4096; i++) wr(mk(6'(i), 3'd0, 4'd0, 16'(i)));
        chk("full_no_err", {31'd0, wr_err}, 32'd0);
        chk("full_addr_sat", {20'd0, mem_addr}, 32'd4095);
        wr(mk(6'd1, 3'd0, 4'd0, 16'd1));
        chk("ovf_wr_err", {31'd0, wr_err}, 32'd1);
        chk("ovf_loaded", {31'd0, loaded}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovf_start_busy", {31'd0, busy}, 32'd0);
        step(); step(); step();
        chk("ovf_still_idle", {31'd0, busy | note_valid}, 32'd0);

        // late note: skipped when the miss window is enabled, presented otherwise
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr(mk(6'd5, 3'd1, 4'd2, 16'd100));
        wr(mk(6'd6, 3'd2, 4'd3, 16'd600));
        wr(END_W);
        song_time = 16'd500;
        note_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(c);
`ifdef NOTE_SCHED_MISS_EN
        chk("miss_pitch", {26'd0, note_pitch}, 32'd6);
        chk("miss_time", {16'd0, note_time}, 32'd600);
        chk("miss_count", {19'd0, missed_count}, 32'd1);
`else
        chk("late_pitch", {26'd0, note_pitch}, 32'd5);
        chk("late_time", {16'd0, note_time}, 32'd100);
`endif
        note_ready = 1'b1;
        step();
        wait_valid(c);
        chk("late_next_pitch", {26'd0, note_pitch}, 32'd6);
        step();
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
